dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the MIPS32 data-memory port: it accepts the level-held read enable and 4-bit byte write enable issued by the CPU's data memory controller and performs the access on an internal single-port, byte-lane RAM. It then returns read data with a one-cycle `DataMem_Ready` pulse. Configurable wait states let the bench and FPGA builds model slower memories. Out-of-range addresses complete normally but are flagged and counted so the CPU never hangs.

## Interface
- `MEM_WORDS`, 4096, RAM depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; aligned to `MEM_WORDS*4`.
- `WAIT_STATES`, 1, extra cycles inserted before the RAM access; legal range 0..15.
- `clock  in  1  single clock; all state updates on its rising edge`
- `reset  in  1  asynchronous, active-low reset`
- `Address  in  32  byte address from CPU; bits [1:0] ignored`
- `MWriteData  in  32  write data, lane-replicated by initiator`
- `WriteEnable  in  4  byte-lane write enables; [3] = bits 31:24`
- `ReadEnable  in  1  read request`
- `MReadData  out  32  read data; valid while `DataMem_Ready` is high, held until next completion`
- `DataMem_Ready  out  1  one-cycle completion pulse`
- `BusError  out  1  pulses with `DataMem_Ready` when the completed access was out of range`
- `ErrCount  out  8  saturating count of out-of-range accesses`

## Operation
- A request is `ReadEnable | (|WriteEnable)`. It is sampled only in IDLE.
- On acceptance, capture `Address[31:2]`, `MWriteData`, `WriteEnable`, and the in-range flag into registers. Inputs are ignored until the state returns to IDLE.
- In-range test: `(Address - BASE_ADDR) >> 2 < MEM_WORDS`, computed with 32-bit unsigned arithmetic. RAM index is the low `$clog2(MEM_WORDS)` bits of the difference.
- The RAM is read-first. Every access returns the word contents from before the write.
- Byte lanes with `WriteEnable[i]=1` are written; the other lanes are unchanged.
- If `ReadEnable` and `WriteEnable` are both asserted, the access is treated as a write, and `MReadData` returns the old word.
- Out-of-range accesses:
  - no RAM write;
  - `MReadData` = 0;
  - `BusError`=1 for the Ready cycle;
  - `ErrCount` increments on the Ready cycle and saturates at 8'hFF.
- FSM states: IDLE, WAIT, ACCESS, READY, DONE.
  - IDLE: request → WAIT if `WAIT_STATES>0`, else ACCESS.
  - WAIT: a 4-bit down-counter is loaded with `WAIT_STATES-1`; move to ACCESS when it reaches 0.
  - ACCESS: the RAM op occurs at this edge and read data is registered → READY.
  - READY: `DataMem_Ready`=1 → DONE.
  - DONE: inputs are ignored for one cycle, since the initiator drops its enables the cycle after Ready → IDLE.
- Reset (any state, asynchronous):
  - state = IDLE;
  - `DataMem_Ready`=0, `BusError`=0, `MReadData`=0, `ErrCount`=0;
  - wait counter = 0.
  - A write whose ACCESS edge has not occurred is dropped.
  - RAM contents are not reset.

## Timing
- If the request is first present in cycle c, `DataMem_Ready` is high in cycle c+2+`WAIT_STATES`, for exactly one cycle.
- The earliest next acceptance is cycle c+4+`WAIT_STATES`, so back-to-back throughput is one access per 4+`WAIT_STATES` cycles.
- `MReadData` changes only at the ACCESS edge and at reset.
- `BusError` is asserted only together with `DataMem_Ready`.
- A request deasserted before the ACCESS edge still completes: the captured values are used.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `mips_pkg` gains:
  - `typedef enum logic [2:0] {DM_IDLE, DM_WAIT, DM_ACCESS, DM_READY, DM_DONE} dmem_state_t`;
  - `localparam DMEM_MAX_WAIT = 15`.
- Sub-module `dmem_sram_sp`: a single-port, read-first, 4-lane byte-enable synchronous RAM with no reset, sized by `MEM_WORDS`; it is inferable as block RAM.
- `dmem_responder` holds the FSM, capture registers, range check, wait counter, and error counter.

## Test plan
- **Word read**, `WAIT_STATES=1`, word 0x10 preloaded with 32'hDEADBEEF; `ReadEnable`, Address 32'h40 in cycle 0 → `DataMem_Ready` high in cycle 3 only; `MReadData`=32'hDEADBEEF held afterwards.
- **Byte write**: `WriteEnable`=4'b0100, `MWriteData`=32'hAAAAAAAA at 32'h40, then read 32'h40 → 32'hDEAABEEF; the write completion returns 32'hDEADBEEF.
- **Zero wait states**: `WAIT_STATES=0`; read in cycle 0 → Ready in cycle 2; the request held through cycle 3 is ignored (DONE); re-presented in cycle 4 → accepted, Ready in cycle 6.
- **Out of range**: read of 32'h0000_4000 with `MEM_WORDS=4096` → Ready plus `BusError` in the same cycle, `MReadData`=0, `ErrCount`=1. After 300 such accesses, `ErrCount`=8'hFF.
- **Reset during wait**: `WAIT_STATES=3`, write of 32'h12345678 to 32'h80; `reset` low in cycle 2 → `DataMem_Ready` never pulses and outputs are 0; a read of 32'h80 after reset returns the old contents.
- **Simultaneous enables**: `ReadEnable`=1 and `WriteEnable`=4'b1111 together → performed as a write; Ready returns the prior word, and a subsequent read returns the new data.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 types and constants.
// Data-memory responder FSM encoding lives here.
package mips_pkg;

  typedef enum logic [2:0] {
    DM_IDLE,
    DM_WAIT,
    DM_ACCESS,
    DM_READY,
    DM_DONE
  } dmem_state_t;

  localparam int DMEM_MAX_WAIT = 15;

endpackage

// File: rtl/dmem_sram_sp.sv
// Single-port read-first byte-lane RAM.
// No reset so synthesis can map it onto block RAM.
module dmem_sram_sp #(
  parameter int MEM_WORDS = 4096,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MIPS32 data-memory responder: FSM, wait states,
// range check and bus-error counter around the RAM.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int          MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] MWriteData,
  input  logic [3:0]  WriteEnable,
  input  logic        ReadEnable,
  output logic [31:0] MReadData,
  output logic        DataMem_Ready,
  output logic        BusError,
  output logic [7:0]  ErrCount
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > DMEM_MAX_WAIT) begin : g_bad_ws
    $error("dmem_responder: WAIT_STATES out of range");
  end

  dmem_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    we_q, we_d;
  logic          inr_q, inr_d;
  logic          rdy_q, rdy_d;
  logic          berr_q, berr_d;
  logic          dok_q, dok_d;
  logic [7:0]    err_q, err_d;

  logic [31:0] diff;
  logic        in_rng;
  logic        req;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  assign diff   = Address - BASE_ADDR;
  assign in_rng = (diff >> 2) < 32'(MEM_WORDS);
  assign req    = ReadEnable | (|WriteEnable);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    inr_d   = inr_q;
    rdy_d   = 1'b0;
    berr_d  = 1'b0;
    dok_d   = dok_q;
    err_d   = err_q;
    unique case (state_q)
      DM_IDLE: begin
        if (req) begin
          idx_d   = diff[AW+1:2];
          wdata_d = MWriteData;
          we_d    = WriteEnable;
          inr_d   = in_rng;
          if (WS != 4'd0) begin
            state_d = DM_WAIT;
            cnt_d   = WS - 4'd1;
          end else begin
            state_d = DM_ACCESS;
          end
        end
      end
      DM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DM_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DM_ACCESS: begin
        state_d = DM_READY;
        rdy_d   = 1'b1;
        berr_d  = ~inr_q;
        dok_d   = inr_q;
        if (!inr_q && err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
      end
      DM_READY: state_d = DM_DONE;
      DM_DONE:  state_d = DM_IDLE;
      default:  state_d = DM_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      inr_q   <= 1'b0;
      rdy_q   <= 1'b0;
      berr_q  <= 1'b0;
      dok_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      inr_q   <= inr_d;
      rdy_q   <= rdy_d;
      berr_q  <= berr_d;
      dok_q   <= dok_d;
      err_q   <= err_d;
    end
  end

  // Out-of-range accesses never touch the RAM.
  assign ram_en = (state_q == DM_ACCESS) && inr_q;
  assign ram_we = we_q & {4{ram_en}};

  dmem_sram_sp #(
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk  (clock),
    .en   (ram_en),
    .we   (ram_we),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // RAM output only moves at the ACCESS edge; the flag zeroes it
  // after reset and after an out-of-range completion.
  assign MReadData     = dok_q ? ram_rdata : 32'h0;
  assign DataMem_Ready = rdy_q;
  assign BusError      = berr_q;
  assign ErrCount      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder at 0, 1 and 3 wait states.
// Instances share inputs; each test checks one instance.
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] MWriteData;
  logic [3:0]  WriteEnable;
  logic        ReadEnable;

  logic [31:0] rd  [3];
  logic        rdy [3];
  logic        be  [3];
  logic [7:0]  ec  [3];

  int ws [3] = '{0, 1, 3};
  int checks = 0;
  int errors = 0;

  dmem_responder #(.MEM_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .Address(Address), .MWriteData(MWriteData),
    .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .MReadData(rd[0]),
    .DataMem_Ready(rdy[0]), .BusError(be[0]), .ErrCount(ec[0]));

  dmem_responder #(.MEM_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (
    .clock(clock), .reset(reset), .Address(Address), .MWriteData(MWriteData),
    .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .MReadData(rd[1]),
    .DataMem_Ready(rdy[1]), .BusError(be[1]), .ErrCount(ec[1]));

  dmem_responder #(.MEM_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .clock(clock), .reset(reset), .Address(Address), .MWriteData(MWriteData),
    .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .MReadData(rd[2]),
    .DataMem_Ready(rdy[2]), .BusError(be[2]), .ErrCount(ec[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  we;
    logic        re;
    logic        ck;
    logic [31:0] exp;
    logic        eb;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic xact(input int s, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] we, input logic re,
                      output logic [31:0] rdo, output logic beo);
    int lat;
    lat = -1;
    rdo = '0;
    beo = 1'b0;
    @(negedge clock);
    Address = a;
    MWriteData = wd;
    WriteEnable = we;
    ReadEnable = re;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (rdy[s]) begin
        lat = n;
        rdo = rd[s];
        beo = be[s];
        break;
      end
    end
    Address = '0;
    MWriteData = '0;
    WriteEnable = '0;
    ReadEnable = 1'b0;
    chk("latency", lat, 32'(2 + ws[s]));
    @(negedge clock);
    chk("ready_one_cycle", {31'b0, rdy[s]}, 32'h0);
    chk("berr_only_with_ready", {31'b0, be[s]}, 32'h0);
  endtask

  logic [31:0] rdo;
  logic        beo;
  int          ecm;
  logic [8:0]  tr;

  initial begin
    tbl[0]  = '{32'h40,       32'hDEADBEEF, 4'hF,    1'b0, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{32'h40,       32'h0,        4'h0,    1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{32'h40,       32'hAAAAAAAA, 4'b0100, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{32'h40,       32'h0,        4'h0,    1'b1, 1'b1, 32'hDEAABEEF, 1'b0};
    tbl[4]  = '{32'h44,       32'h01234567, 4'hF,    1'b0, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{32'h47,       32'hFFFFFFFF, 4'b1001, 1'b0, 1'b1, 32'h01234567, 1'b0};
    tbl[6]  = '{32'h44,       32'h0,        4'h0,    1'b1, 1'b1, 32'hFF2345FF, 1'b0};
    tbl[7]  = '{32'h3FFC,     32'h5A5A5A5A, 4'hF,    1'b0, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{32'h3FFC,     32'h0,        4'h0,    1'b1, 1'b1, 32'h5A5A5A5A, 1'b0};
    tbl[9]  = '{32'h4000,     32'h0,        4'h0,    1'b1, 1'b1, 32'h0,        1'b1};
    tbl[10] = '{32'hFFFFFFFC, 32'h11111111, 4'hF,    1'b0, 1'b1, 32'h0,        1'b1};
    tbl[11] = '{32'h40,       32'hCAFEBABE, 4'hF,    1'b1, 1'b1, 32'hDEAABEEF, 1'b0};

    Address = '0;
    MWriteData = '0;
    WriteEnable = '0;
    ReadEnable = 1'b0;
    reset = 1'b0;
    idle(3);
    for (int k = 0; k < 3; k++) begin
      chk("reset_rdata", rd[k], 32'h0);
      chk("reset_ready", {31'b0, rdy[k]}, 32'h0);
      chk("reset_berr", {31'b0, be[k]}, 32'h0);
      chk("reset_errcnt", {24'b0, ec[k]}, 32'h0);
    end
    reset = 1'b1;
    idle(2);

    ecm = 0;
    for (int i = 0; i < 12; i++) begin
      xact(1, tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].re, rdo, beo);
      if (tbl[i].ck) chk("rdata", rdo, tbl[i].exp);
      chk("berr", {31'b0, beo}, {31'b0, tbl[i].eb});
      if (tbl[i].eb) ecm++;
      chk("errcnt", {24'b0, ec[1]}, 32'(ecm));
      idle(3);
      if (tbl[i].ck) chk("rdata_held", rd[1], tbl[i].exp);
    end
    xact(1, 32'h40, 32'h0, 4'h0, 1'b1, rdo, beo);
    chk("rmw_new_data", rdo, 32'hCAFEBABE);
    idle(6);

    // Zero wait states: held request ignored in DONE, re-accepted after.
    @(negedge clock);
    Address = 32'h40;
    ReadEnable = 1'b1;
    tr = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      tr[k] = rdy[0];
      if (k == 5) ReadEnable = 1'b0;
    end
    Address = '0;
    chk("zero_ws_trace", {23'b0, tr}, 32'h044);
    chk("zero_ws_rdata", rd[0], 32'hCAFEBABE);
    idle(6);

    for (int i = 0; i < 300; i++) begin
      xact(1, 32'h4000, 32'h0, 4'h0, 1'b1, rdo, beo);
      if (i == 0) begin
        chk("oor_rdata", rdo, 32'h0);
        chk("oor_berr", {31'b0, beo}, 32'h1);
      end
      idle(2);
    end
    chk("errcnt_sat", {24'b0, ec[1]}, 32'hFF);
    idle(8);

    // Reset while the W=3 instance is still waiting on a write.
    xact(2, 32'h80, 32'hCAFEF00D, 4'hF, 1'b0, rdo, beo);
    idle(6);
    @(negedge clock);
    Address = 32'h80;
    MWriteData = 32'h12345678;
    WriteEnable = 4'hF;
    idle(2);
    reset = 1'b0;
    Address = '0;
    MWriteData = '0;
    WriteEnable = '0;
    @(negedge clock);
    chk("rst_rdata", rd[2], 32'h0);
    chk("rst_errcnt", {24'b0, ec[2]}, 32'h0);
    chk("rst_errcnt1", {24'b0, ec[1]}, 32'h0);
    chk("rst_berr", {31'b0, be[2]}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tr = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      tr[k] = rdy[2];
    end
    chk("rst_no_ready", {23'b0, tr}, 32'h0);
    xact(2, 32'h80, 32'h0, 4'h0, 1'b1, rdo, beo);
    chk("rst_dropped_write", rdo, 32'hCAFEF00D);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
